// File: rtl/vmem_pkg.sv
// Shared types and constants for the vector memory responder.
package vmem_pkg;

    localparam int VEC_W      = 128;  // vector width in bits
    localparam int LANES      = 16;   // byte lanes per vector
    localparam int LANE_W     = 8;    // bits per lane
    localparam int DEF_WORD_W = 32;   // default RAM word width
    localparam int VEC_BEATS  = VEC_W / DEF_WORD_W;  // RAM beats per vector

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_LAST,
        RESP
    } vmem_state_t;

endpackage

// File: rtl/vmem_beat_assembler.sv
// 128-bit vector register with whole-vector load and per-beat write.
// The top uses one copy to hold store data and another to gather load beats.
module vmem_beat_assembler
    import vmem_pkg::*;
#(
    parameter  int WORD_W = DEF_WORD_W,
    parameter  int BEATS  = VEC_BEATS,
    localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_all_i,
    input  logic [WORD_W*BEATS-1:0]   all_data_i,
    input  logic                      beat_we_i,
    input  logic [IDX_W-1:0]          beat_idx_i,
    input  logic [WORD_W-1:0]         beat_data_i,
    output logic [WORD_W*BEATS-1:0]   vec_o
);

    logic [WORD_W*BEATS-1:0] vec_q;

    // Vector register: full load takes priority over a single-beat write.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // this register is plain flops (not a RAM macro), so resetting it is cheap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vec_q <= '0;
        end else if (load_all_i) begin
            vec_q <= all_data_i;
        end else if (beat_we_i) begin
            vec_q[beat_idx_i*WORD_W +: WORD_W] <= beat_data_i;
        end
    end

    assign vec_o = vec_q;

endmodule

// File: rtl/vec_mem_responder.sv
// Serialises 128-bit vector loads/stores into 32-bit RAM beats and
// reassembles load beats into a single 128-bit response.
module vec_mem_responder
    import vmem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int WORD_W = DEF_WORD_W,
    parameter int BEATS  = VEC_W / WORD_W,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [VEC_W-1:0]   req_wdata,
    output logic               req_ready,
    output logic               rsp_valid,
    output logic [VEC_W-1:0]   rsp_rdata,
    output logic               stall,
    output logic               err_misalign,
    output logic [ADDR_W-3:0]  ram_addr,
    output logic               ram_we,
    output logic [WORD_W-1:0]  ram_wdata,
    input  logic [WORD_W-1:0]  ram_rdata
);

    localparam int K_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WA_W = ADDR_W - 2;

    vmem_state_t       state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [WA_W-1:0]   base_q, base_d;
    logic              err_q, err_d;

    logic              accept;
    logic              misalign;
    logic              go;
    logic              cap_en;
    logic [K_W-1:0]    cap_idx;
    logic [VEC_W-1:0]  wdata_vec;

    assign accept   = req_valid && (state_q == IDLE);
    assign misalign = (req_addr[3:0] != 4'd0);
    assign go       = accept && !misalign;

    // Next-state, beat counter, base latch and load-capture control.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        err_d   = accept && misalign;
        cap_en  = 1'b0;
        cap_idx = '0;

        unique case (state_q)
            IDLE: begin
                if (go) begin
                    base_d  = req_addr[ADDR_W-1:2];
                    k_d     = '0;
                    state_d = req_we ? WR : RD;
                end
            end
            WR: begin
                if (k_q == K_W'(BEATS - 1)) begin
                    state_d = IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            RD: begin
                // Read data lags its address by RD_LAT cycles.
                if (k_q >= K_W'(RD_LAT)) begin
                    cap_en  = 1'b1;
                    cap_idx = k_q - K_W'(RD_LAT);
                end
                if (k_q == K_W'(BEATS - 1)) begin
                    state_d = RD_LAST;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            RD_LAST: begin
                cap_en  = 1'b1;
                cap_idx = K_W'(BEATS - 1);
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, base address and misalign pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            base_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
            err_q   <= err_d;
        end
    end

    // Store data is latched whole on acceptance and sliced per beat below.
    vmem_beat_assembler #(
        .WORD_W (WORD_W),
        .BEATS  (BEATS)
    ) u_store_buf (
        .clk         (clk),
        .reset       (reset),
        .load_all_i  (go),
        .all_data_i  (req_wdata),
        .beat_we_i   (1'b0),
        .beat_idx_i  ('0),
        .beat_data_i ('0),
        .vec_o       (wdata_vec)
    );

    // Load beats are gathered here; the value persists across stores.
    vmem_beat_assembler #(
        .WORD_W (WORD_W),
        .BEATS  (BEATS)
    ) u_load_buf (
        .clk         (clk),
        .reset       (reset),
        .load_all_i  (1'b0),
        .all_data_i  ('0),
        .beat_we_i   (cap_en),
        .beat_idx_i  (cap_idx),
        .beat_data_i (ram_rdata),
        .vec_o       (rsp_rdata)
    );

    assign req_ready    = (state_q == IDLE);
    assign stall        = (state_q != IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign err_misalign = err_q;
    assign ram_we       = (state_q == WR);
    assign ram_addr     = ((state_q == WR) || (state_q == RD)) ? (base_q + WA_W'(k_q)) : '0;
    assign ram_wdata    = (state_q == WR) ? wdata_vec[k_q*WORD_W +: WORD_W] : '0;

endmodule

// File: tb/tb_vec_mem_responder.sv
// Directed bench for vec_mem_responder with a 1-cycle-latency RAM model.
module tb_vec_mem_responder;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_we;
    logic [15:0]   req_addr;
    logic [127:0]  req_wdata;
    logic          req_ready;
    logic          rsp_valid;
    logic [127:0]  rsp_rdata;
    logic          stall;
    logic          err_misalign;
    logic [13:0]   ram_addr;
    logic          ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [31:0]   mem [0:16383];

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] V1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] D1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] D2 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] D3 = 128'h99999999_88888888_77777777_66666666;

    logic [31:0] w1 [4];
    logic [31:0] wd1 [4];
    logic [31:0] wd2 [4];

    always #5 clk = ~clk;

    vec_mem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .stall        (stall),
        .err_misalign (err_misalign),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    // Synchronous RAM, read-before-write, one cycle of read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request just after a clock edge, confirm it is acceptable,
    // and keep it up through the accepting edge.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [127:0] d);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = d;
        @(negedge clk);
        chk("ready_before_accept", req_ready, 1'b1);
        chk("stall_on_accept", stall, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic drop_req();
        req_valid = 1'b0;
    endtask

    initial begin
        w1[0] = 32'h03020100; w1[1] = 32'h07060504; w1[2] = 32'h0B0A0908; w1[3] = 32'h0F0E0D0C;
        wd1[0] = 32'hAAAAAAAA; wd1[1] = 32'hBBBBBBBB; wd1[2] = 32'hCCCCCCCC; wd1[3] = 32'hDDDDDDDD;
        wd2[0] = 32'h11111111; wd2[1] = 32'h22222222; wd2[2] = 32'h33333333; wd2[3] = 32'h44444444;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_stall", stall, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_err", err_misalign, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 128'h0);
        chk("rst_ram_addr", ram_addr, 14'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // 1: aligned store at 0x0010
        issue(1'b1, 16'h0010, V1);
        drop_req();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("t1_we_c%0d", c), ram_we, 1'b1);
            chk($sformatf("t1_addr_c%0d", c), ram_addr, 14'h4 + 14'(c - 1));
            chk($sformatf("t1_wdata_c%0d", c), ram_wdata, w1[c-1]);
            chk($sformatf("t1_stall_c%0d", c), stall, 1'b1);
            chk($sformatf("t1_ready_c%0d", c), req_ready, 1'b0);
        end
        @(negedge clk);
        chk("t1_we_c5", ram_we, 1'b0);
        chk("t1_ready_c5", req_ready, 1'b1);
        chk("t1_stall_c5", stall, 1'b0);

        // 2: load back from 0x0010
        issue(1'b0, 16'h0010, '0);
        drop_req();
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("t2_stall_c%0d", c), stall, 1'b1);
            chk($sformatf("t2_rsp_valid_c%0d", c), rsp_valid, (c == 6));
            if (c <= 4) begin
                chk($sformatf("t2_we_c%0d", c), ram_we, 1'b0);
                chk($sformatf("t2_addr_c%0d", c), ram_addr, 14'h4 + 14'(c - 1));
            end
        end
        chk("t2_rdata", rsp_rdata, V1);
        @(negedge clk);
        chk("t2_stall_c7", stall, 1'b0);
        chk("t2_rsp_valid_c7", rsp_valid, 1'b0);
        chk("t2_ready_c7", req_ready, 1'b1);
        chk("t2_rdata_hold", rsp_rdata, V1);

        // 3: misaligned load at 0x0014
        issue(1'b0, 16'h0014, '0);
        drop_req();
        @(negedge clk);
        chk("t3_err_c1", err_misalign, 1'b1);
        chk("t3_we_c1", ram_we, 1'b0);
        chk("t3_addr_c1", ram_addr, 14'h0);
        chk("t3_ready_c1", req_ready, 1'b1);
        chk("t3_stall_c1", stall, 1'b0);
        chk("t3_rsp_valid_c1", rsp_valid, 1'b0);
        @(negedge clk);
        chk("t3_err_c2", err_misalign, 1'b0);
        chk("t3_we_c2", ram_we, 1'b0);
        chk("t3_rsp_valid_c2", rsp_valid, 1'b0);
        chk("t3_rdata_hold", rsp_rdata, V1);

        // 4: store at top of address space, then at zero
        issue(1'b1, 16'hFFF0, D1);
        drop_req();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("t4a_we_c%0d", c), ram_we, 1'b1);
            chk($sformatf("t4a_addr_c%0d", c), ram_addr, 14'h3FFC + 14'(c - 1));
            chk($sformatf("t4a_wdata_c%0d", c), ram_wdata, wd1[c-1]);
        end
        issue(1'b1, 16'h0000, D2);
        drop_req();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("t4b_we_c%0d", c), ram_we, 1'b1);
            chk($sformatf("t4b_addr_c%0d", c), ram_addr, 14'(c - 1));
            chk($sformatf("t4b_wdata_c%0d", c), ram_wdata, wd2[c-1]);
        end

        // 5: request held during a load; second one waits for IDLE
        issue(1'b0, 16'hFFF0, '0);
        req_addr = 16'h0000;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            chk($sformatf("t5_rsp_valid_c%0d", c), rsp_valid, (c == 6) || (c == 13));
            chk($sformatf("t5_ready_c%0d", c), req_ready, (c == 7) || (c == 14));
            if (c == 6)  chk("t5_rdata_first", rsp_rdata, D1);
            if (c == 13) chk("t5_rdata_second", rsp_rdata, D2);
            @(posedge clk); #1;
            if (c == 7) drop_req();
        end

        // 6: reset during store beat 2
        issue(1'b1, 16'h0020, D3);
        drop_req();
        repeat (3) @(negedge clk);
        chk("t6_we_beat2", ram_we, 1'b1);
        chk("t6_addr_beat2", ram_addr, 14'hA);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_we", ram_we, 1'b0);
        chk("t6_rst_ready", req_ready, 1'b1);
        chk("t6_rst_stall", stall, 1'b0);
        chk("t6_rst_rsp_valid", rsp_valid, 1'b0);
        chk("t6_rst_rdata", rsp_rdata, 128'h0);
        chk("t6_rst_addr", ram_addr, 14'h0);
        @(negedge clk);
        reset = 1'b1;
        issue(1'b0, 16'h0010, '0);
        drop_req();
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk($sformatf("t6_rsp_valid_c%0d", c), rsp_valid, (c == 6));
            if (c == 6) chk("t6_rdata", rsp_rdata, V1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
